// File: rtl/traffic_light_ctrl_param.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_param
//
// Two-road (main/side) traffic-light controller with parametrised phase
// times and tick rate. The phase order is
// MAIN_GREEN -> MAIN_YEL -> SIDE_GREEN -> SIDE_YEL -> MAIN_GREEN.
// A side-road request is captured sticky and clamps the remaining main
// green down to MIN_GREEN_T. The ticks left in the current phase are shown
// on an active-low 7-segment digit.
//
// Optional feature, enabled by defining NIGHT_FLASH_EN:
//   Adds the 'night' input and a FLASH state. In FLASH both yellows blink
//   once per tick. The default build has neither the port nor the state.
//
// Ports:
//   clk      in   1      system clock, all logic on posedge
//   rst      in   1      synchronous, active-high reset
//   request  in   1      side-road request, level or single-cycle pulse
//   night    in   1      night-flash select (NIGHT_FLASH_EN builds only)
//   light    out  6      {main G, main Y, main R, side G, side Y, side R}
//   phase    out  2      0=MAIN_GREEN 1=MAIN_YEL 2=SIDE_GREEN 3=SIDE_YEL
//   remain   out  CNT_W  ticks left in the current phase, current included
//   sevseg   out  8      [6:0] active-low segments g..a of hex(remain[3:0]),
//                        [7] decimal point, held off (1)
// ---------------------------------------------------------------------------
module traffic_light_ctrl_param #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int CNT_W        = 4,
   parameter int MAIN_GREEN_T = 10,
   parameter int MAIN_YEL_T   = 2,
   parameter int SIDE_GREEN_T = 5,
   parameter int SIDE_YEL_T   = 2,
   parameter int MIN_GREEN_T  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             request,
`ifdef NIGHT_FLASH_EN
   input  logic             night,
`endif
   output logic [5:0]       light,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] remain,
   output logic [7:0]       sevseg
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   // A phase time of 0 would make the phase vanish. It is loaded as 1 so
   // that every phase is visible for at least one tick.
   localparam logic [CNT_W-1:0] MAIN_GREEN_LD = (MAIN_GREEN_T < 1) ? CNT_W'(1) : CNT_W'(MAIN_GREEN_T);
   localparam logic [CNT_W-1:0] MAIN_YEL_LD   = (MAIN_YEL_T   < 1) ? CNT_W'(1) : CNT_W'(MAIN_YEL_T);
   localparam logic [CNT_W-1:0] SIDE_GREEN_LD = (SIDE_GREEN_T < 1) ? CNT_W'(1) : CNT_W'(SIDE_GREEN_T);
   localparam logic [CNT_W-1:0] SIDE_YEL_LD   = (SIDE_YEL_T   < 1) ? CNT_W'(1) : CNT_W'(SIDE_YEL_T);
   localparam logic [CNT_W-1:0] MIN_GREEN_LD  = CNT_W'(MIN_GREEN_T);

   localparam logic [5:0] LIGHT_MAIN_GREEN = 6'b100001;
   localparam logic [5:0] LIGHT_MAIN_YEL   = 6'b010001;
   localparam logic [5:0] LIGHT_SIDE_GREEN = 6'b001100;
   localparam logic [5:0] LIGHT_SIDE_YEL   = 6'b001010;
   localparam logic [5:0] LIGHT_FLASH_ON   = 6'b010010;
   localparam logic [5:0] LIGHT_DARK       = 6'b000000;

`ifdef NIGHT_FLASH_EN
   typedef enum logic [2:0] {
      ST_MAIN_GREEN = 3'd0,
      ST_MAIN_YEL   = 3'd1,
      ST_SIDE_GREEN = 3'd2,
      ST_SIDE_YEL   = 3'd3,
      ST_FLASH      = 3'd4
   } ctrlState_t;
`else
   typedef enum logic [1:0] {
      ST_MAIN_GREEN = 2'd0,
      ST_MAIN_YEL   = 2'd1,
      ST_SIDE_GREEN = 2'd2,
      ST_SIDE_YEL   = 2'd3
   } ctrlState_t;
`endif

   ctrlState_t       state;
   ctrlState_t       stateNext;
   logic [TICK_W-1:0] tickCnt;
   logic             tick;
   logic             reqLat;
   logic             reqLatNext;
   logic             reqNow;
   logic             enterSide;
   logic             nightReq;
   logic             inFlash;
   logic [CNT_W-1:0] remainNext;
   logic [5:0]       lightNext;

   // Active-low hex font for the 7-segment digit, segment order g..a.
   function automatic logic [6:0] hexSegments(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   assign tick = (tickCnt == TICK_LAST);

   // A request arriving in the same cycle as a tick must already count for
   // that tick's decision, so the live input is merged with the latch.
   assign reqNow = reqLat | request;

`ifdef NIGHT_FLASH_EN
   assign nightReq = night;
   assign inFlash  = (state == ST_FLASH);
`else
   assign nightReq = 1'b0;
   assign inFlash  = 1'b0;
`endif

   // Tick prescaler: free-running divider. It yields a one-cycle tick
   // every TICK_DIV clocks, the first one TICK_DIV cycles after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tickCnt <= '0;
      end else if (tick) begin
         tickCnt <= '0;
      end else begin
         tickCnt <= tickCnt + TICK_W'(1);
      end
   end

   // Next-state and datapath decisions. Between ticks everything holds,
   // apart from request capture. On a tick, night mode has priority. Then
   // come the end-of-phase advance, the main-green clamp, and finally the
   // ordinary countdown. The clamp only pulls remain down, never up, so a
   // late request in a short main green has no effect.
   always_comb begin
      stateNext  = state;
      remainNext = remain;
      lightNext  = light;
      enterSide  = 1'b0;
      if (tick) begin
         if (nightReq) begin
`ifdef NIGHT_FLASH_EN
            stateNext = ST_FLASH;
`endif
            remainNext = '0;
            lightNext  = (inFlash && (light == LIGHT_FLASH_ON)) ? LIGHT_DARK : LIGHT_FLASH_ON;
         end else if (inFlash) begin
            stateNext  = ST_MAIN_GREEN;
            remainNext = MAIN_GREEN_LD;
            lightNext  = LIGHT_MAIN_GREEN;
         end else if (remain <= CNT_W'(1)) begin
            case (state)
               ST_MAIN_GREEN: begin
                  stateNext  = ST_MAIN_YEL;
                  remainNext = MAIN_YEL_LD;
                  lightNext  = LIGHT_MAIN_YEL;
               end
               ST_MAIN_YEL: begin
                  stateNext  = ST_SIDE_GREEN;
                  remainNext = SIDE_GREEN_LD;
                  lightNext  = LIGHT_SIDE_GREEN;
                  enterSide  = 1'b1;
               end
               ST_SIDE_GREEN: begin
                  stateNext  = ST_SIDE_YEL;
                  remainNext = SIDE_YEL_LD;
                  lightNext  = LIGHT_SIDE_YEL;
               end
               default: begin
                  stateNext  = ST_MAIN_GREEN;
                  remainNext = MAIN_GREEN_LD;
                  lightNext  = LIGHT_MAIN_GREEN;
               end
            endcase
         end else if ((state == ST_MAIN_GREEN) && reqNow && (remain > MIN_GREEN_LD)) begin
            remainNext = MIN_GREEN_LD;
         end else begin
            remainNext = remain - CNT_W'(1);
         end
      end
      reqLatNext = enterSide ? 1'b0 : reqNow;
   end

   // FSM state register. Reset always restarts in MAIN_GREEN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_MAIN_GREEN;
      end else begin
         state <= stateNext;
      end
   end

   // Datapath registers. light is updated on the same edge as the state.
   // sevseg follows remain one clock later and is blanked by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         remain <= MAIN_GREEN_LD;
         light  <= LIGHT_MAIN_GREEN;
         reqLat <= 1'b0;
         sevseg <= 8'hFF;
      end else begin
         remain <= remainNext;
         light  <= lightNext;
         reqLat <= reqLatNext;
         sevseg <= {1'b1, hexSegments(4'(remain))};
      end
   end

   // Externally visible phase number. FLASH reports itself as the
   // main-yellow phase.
   always_comb begin
      phase = 2'(state);
      if (inFlash) begin
         phase = 2'd1;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_ctrl_param
//
// Bench for traffic_light_ctrl_param with TICK_DIV=4 and default times.
// A rule-level model of the controller tracks phase, ticks left, pending
// request and display. A compare process checks all DUT outputs against
// this model on every falling edge. Directed scenarios drive the inputs.
// They also pin the model with hand-computed phase lengths and values.
// If NIGHT_FLASH_EN is defined, the night port and a flash scenario are
// included.
// ---------------------------------------------------------------------------
module tb_traffic_light_ctrl_param;

   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 4;
   localparam int MIN_T    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             request;
   logic             night;
   logic [5:0]       light;
   logic [1:0]       phase;
   logic [CNT_W-1:0] remain;
   logic [7:0]       sevseg;

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   int         phaseTicks [4] = '{10, 2, 5, 2};
   logic [5:0] phaseLights[4] = '{6'b100001, 6'b010001, 6'b001100, 6'b001010};
   logic [6:0] hexFont   [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int         mCnt = 0;
   int         mPhase = 0;
   int         mRemain = 10;
   bit         mReq = 1'b0;
   logic [5:0] mLight = 6'b100001;
   logic [7:0] mSev = 8'hFF;
   bit         mTick;
   bit         mReqNow;
   bit         mClear;
   bit         mNight;

   traffic_light_ctrl_param #(
      .TICK_DIV(TICK_DIV),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .request(request),
`ifdef NIGHT_FLASH_EN
      .night(night),
`endif
      .light(light),
      .phase(phase),
      .remain(remain),
      .sevseg(sevseg)
   );

   // 100 MHz bench clock.
   always #5 clk = ~clk;

   // Abort if the run hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   // Rule-level model. It keeps a phase index (4 = flash), the whole ticks
   // left and a pending-request flag. Each phase uses its duration from
   // the table and the lights are looked up per phase. The display shows
   // the value left before this clock edge.
   always @(posedge clk) begin
`ifdef NIGHT_FLASH_EN
      mNight = night;
`else
      mNight = 1'b0;
`endif
      if (rst) begin
         mCnt    = 0;
         mPhase  = 0;
         mRemain = phaseTicks[0];
         mReq    = 1'b0;
         mLight  = phaseLights[0];
         mSev    = 8'hFF;
      end else begin
         mSev    = {1'b1, hexFont[mRemain % 16]};
         mTick   = (mCnt == TICK_DIV - 1);
         mCnt    = mTick ? 0 : mCnt + 1;
         mReqNow = mReq || request;
         mClear  = 1'b0;
         if (mTick) begin
            if (mNight) begin
               mLight  = (mPhase == 4 && mLight == 6'b010010) ? 6'b000000 : 6'b010010;
               mPhase  = 4;
               mRemain = 0;
            end else if (mPhase == 4) begin
               mPhase  = 0;
               mRemain = phaseTicks[0];
               mLight  = phaseLights[0];
            end else if (mRemain <= 1) begin
               mPhase  = (mPhase + 1) % 4;
               mRemain = (phaseTicks[mPhase] < 1) ? 1 : phaseTicks[mPhase];
               mLight  = phaseLights[mPhase];
               mClear  = (mPhase == 2);
            end else if (mPhase == 0 && mReqNow && mRemain > MIN_T) begin
               mRemain = MIN_T;
            end else begin
               mRemain = mRemain - 1;
            end
         end
         mReq = mClear ? 1'b0 : mReqNow;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic q, input logic n);
      rst     = r;
      request = q;
      night   = n;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("light", int'(light), int'(mLight));
         checkOutput("phase", int'(phase), (mPhase == 4) ? 1 : mPhase);
         checkOutput("remain", int'(remain), mRemain);
         checkOutput("sevseg", int'(sevseg), int'(mSev));
      end
   end

   // Count the falling edges the DUT spends in phase p, starting at the
   // current one. Also check the light shown on entry.
   task automatic measurePhase(input int p, input int expLen);
      int count = 0;
      checkOutput($sformatf("light at phase %0d entry", p), int'(light), int'(phaseLights[p]));
      while (int'(phase) == p && count < 200) begin
         @(negedge clk);
         count++;
      end
      checkOutput($sformatf("length of phase %0d", p), count, expLen);
   endtask

   task automatic waitRemain(input int value, input int maxCycles);
      int count = 0;
      while (int'(remain) != value && count < maxCycles) begin
         @(negedge clk);
         count++;
      end
      checkOutput($sformatf("reach remain=%0d", value), int'(remain), value);
   endtask

   task automatic pulseRequest();
      applyStimulus(1'b0, 1'b1, night);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, night);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkEn = 1'b1;
      checkOutput("reset phase", int'(phase), 0);
      checkOutput("reset remain", int'(remain), 10);
      checkOutput("reset light", int'(light), 'h21);
      checkOutput("reset sevseg", int'(sevseg), 'hFF);

      // Free-running cycle without any request.
      measurePhase(0, 40);
      measurePhase(1, 8);
      measurePhase(2, 20);
      measurePhase(3, 8);

      // Request pulse at remain=9 clamps the next tick to 5.
      waitRemain(9, 8);
      pulseRequest();
      waitRemain(5, 6);
      measurePhase(0, 20);
      measurePhase(1, 8);
      measurePhase(2, 20);
      measurePhase(3, 8);
      measurePhase(0, 40);
      measurePhase(1, 8);
      measurePhase(2, 20);

      // Request during SIDE_YEL is held for the following main green.
      pulseRequest();
      measurePhase(3, 7);
      measurePhase(0, 24);
      measurePhase(1, 8);
      measurePhase(2, 20);
      measurePhase(3, 8);

      // Request with remain <= MIN_GREEN_T does not change the countdown.
      waitRemain(4, 30);
      pulseRequest();
      measurePhase(0, 15);
      measurePhase(1, 8);

      // Reset mid side green at remain=3.
      waitRemain(3, 20);
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post-rst phase", int'(phase), 0);
      checkOutput("post-rst remain", int'(remain), 10);
      checkOutput("post-rst light", int'(light), 'h21);
      checkOutput("post-rst sevseg", int'(sevseg), 'hFF);
      @(negedge clk);
      checkOutput("post-rst sevseg A", int'(sevseg), 'h88);
      measurePhase(0, 39);

`ifdef NIGHT_FLASH_EN
      measurePhase(1, 8);
      measurePhase(2, 20);
      measurePhase(3, 8);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("flash phase", int'(phase), 1);
      checkOutput("flash remain", int'(remain), 0);
      checkOutput("flash light on", int'(light), 'h12);
      repeat (4) @(negedge clk);
      checkOutput("flash light off", int'(light), 'h00);
      repeat (4) @(negedge clk);
      checkOutput("flash light on again", int'(light), 'h12);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("flash exit phase", int'(phase), 0);
      checkOutput("flash exit remain", int'(remain), 10);
      checkOutput("flash exit light", int'(light), 'h21);
      repeat (4) @(negedge clk);
`else
      measurePhase(1, 8);
      measurePhase(2, 20);
`endif

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
